serial_twos_comp: RTL and testbench
===================================

# serial_twos_comp

Parametrised, multi-lane, bit-serial two's-complement negator with word framing. Each lane receives words LSB first. Each word passes through unchanged up to and including its first 1 bit; when negation is selected, every later bit is inverted. A shared bit counter marks word boundaries, and an optional flag reports negation of the most-negative value. The block sits on the serial arithmetic datapath and replaces the single-lane, unframed complementer.

## Interface
Parameters:
- W, 8: word width in bits; must be 2 or more.
- LANES, 1: number of independent serial lanes; all lanes share the framing counter.

Ports:
- t_clk  in  1  clock; all state changes on its rising edge.
- r  in  1  reset; asynchronous, active-low.
- i_valid  in  1  a bit is present on every lane this cycle.
- i_sof  in  1  start of word; forces the current bit to be bit 0.
- i_bit  in  LANES  one serial input bit per lane, LSB first.
- neg  in  1  mode: 1 = negate, 0 = pass through. Sampled only on bit 0 and held for the rest of the word.
- o_valid  out  1  registered copy of i_valid.
- o_bit  out  LANES  result bits.
- o_last  out  1  set when the output bit is bit W-1 of a word.
- ovf  out  LANES  overflow flag; only present when SERIAL_TC_OVF_EN is defined.

## Operation
- Bit counter `cnt`, width clog2(W):
  - Advances only on cycles with i_valid=1.
  - Wraps from W-1 to 0.
  - When i_sof=1 and i_valid=1 together, the current bit is bit 0 and `cnt` becomes 1 afterwards.
  - i_sof with i_valid=0 sets `cnt` to 0.
- Mode register `mode`: loaded from neg when a valid bit-0 is accepted. neg has no effect on any other bit.
- Per-lane flag `seen`: records that a 1 has already passed in the current word. For bit 0, `seen` is treated as 0.
- Output per lane: o_bit = i_bit XOR (eff_mode AND eff_seen).
  - On bit 0, eff_mode is the live neg input.
  - On all other bits, eff_mode is `mode`.
- Flag update: `seen` becomes eff_seen OR i_bit. On bit W-1 it is cleared instead.
- Word state: a word in progress is abandoned on i_sof or on reset. The next bit starts fresh. No partial-word output is flagged.
- Idle cycles (i_valid=0): leave all state unchanged. o_valid=0 on the following cycle, and o_bit/o_last hold their last values.
- Independent lanes: every lane applies the same `mode` and counter to its own bit.

## Timing
- Latency: 1 cycle. The output for the bit presented at edge n appears after edge n.
- Throughput: one bit per lane per cycle.
- No backpressure. The consumer must accept every cycle where o_valid=1.
- Reset values: o_valid=0, o_bit=0, o_last=0, ovf=0, `cnt`=0, `mode`=0, `seen`=0.
  - Reset acts immediately, not at the next edge.
  - Deassertion is synchronised externally.
- ovf:
  - Pulses for one cycle together with o_last.
  - Set when eff_mode=1, bit W-1 of that lane is 1, and `seen` was 0 (input was -2^(W-1)). The output word equals the input in that case.
  - Cleared on the next valid bit.

## Configuration
- SERIAL_TC_OVF_EN defined: the ovf port and its detection logic exist.
- Not defined: the port is absent. All other behaviour is identical, cycle for cycle.

## Structure
- Package serial_tc_pkg holds:
  - the default W and LANES constants;
  - the counter-width function;
  - a mode enum: TC_PASS=0, TC_NEG=1.
- Sub-module serial_tc_lane holds one lane's `seen` flag, the XOR output stage and the ovf detection. It is instantiated LANES times in a generate loop.
- The top level holds the shared counter, the `mode` register, o_valid and o_last.

## Test plan
Settings for all scenarios: W=8, LANES=2.
- Negate +6: lane0 = 0x06 (0,1,1,0,0,0,0,0), neg=1 on bit 0 -> o_bit0 = 0,1,0,1,1,1,1,1 (0xFA); o_last on the 8th output only.
- Pass mode: neg=0, lane1 = 0x5A -> output is 0x5A, unchanged, 1 cycle later. Raising neg on bit 3 has no effect.
- Boundary values with neg=1:
  - 0x80 -> 0x80 with ovf=1 at o_last;
  - 0x00 -> 0x00 with ovf=0;
  - 0x01 -> 0xFF.
- Gaps and resync:
  - i_valid=0 for 3 cycles in mid-word -> no counter advance, same result as without the gaps;
  - i_sof at bit 4 -> a new word starts and o_last lands 8 valid bits later.
- Reset mid-word: assert r low at bit 5 -> all outputs are 0 immediately, and the next word is processed correctly from bit 0.
- Back-to-back words: 0x01 followed by 0x02, both neg=1 -> 0xFF then 0xFE. `seen` is cleared at the boundary.

Source files
------------

// File: rtl/serial_tc_pkg.sv
// Shared constants, counter-width helper and mode encoding for the
// multi-lane bit-serial two's-complement negator.
package serial_tc_pkg;

    localparam int unsigned W_DEF     = 8;
    localparam int unsigned LANES_DEF = 1;

    typedef enum logic {
        TC_PASS = 1'b0,
        TC_NEG  = 1'b1
    } tc_mode_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_tc_lane.sv
// One serial lane: first-one tracking, conditional inversion and output register.
// Overflow detection exists only when SERIAL_TC_OVF_EN is defined.
module serial_tc_lane
(
    input  logic t_clk,
    input  logic r,
    input  logic i_valid,
    input  logic i_first,
    input  logic i_last,
    input  logic i_mode,
    input  logic i_bit,
`ifdef SERIAL_TC_OVF_EN
    output logic o_ovf,
`endif
    output logic o_bit
);

    logic seen_q, seen_d;
    logic bit_q, bit_d;
    logic eff_seen;

    // Bit 0 never inherits the previous word's flag, so i_sof needs no lane reset.
    assign eff_seen = i_first ? 1'b0 : seen_q;

    always_comb begin
        seen_d = seen_q;
        bit_d  = bit_q;
        if (i_valid) begin
            bit_d  = i_bit ^ (i_mode & eff_seen);
            seen_d = i_last ? 1'b0 : (eff_seen | i_bit);
        end
    end

    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            seen_q <= 1'b0;
            bit_q  <= 1'b0;
        end else begin
            seen_q <= seen_d;
            bit_q  <= bit_d;
        end
    end

    assign o_bit = bit_q;

`ifdef SERIAL_TC_OVF_EN
    logic ovf_q, ovf_d;

    // Only the most-negative value reaches the sign bit with no earlier 1.
    always_comb begin
        ovf_d = ovf_q;
        if (i_valid) begin
            ovf_d = i_mode & i_last & i_bit & ~eff_seen;
        end
    end

    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_ovf = ovf_q;
`endif

endmodule

// File: rtl/serial_twos_comp.sv
// Multi-lane bit-serial two's-complement negator with shared word framing.
// Define SERIAL_TC_OVF_EN to add the per-lane ovf output.
module serial_twos_comp
    import serial_tc_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned LANES = LANES_DEF
)
(
    input  logic             t_clk,
    input  logic             r,
    input  logic             i_valid,
    input  logic             i_sof,
    input  logic [LANES-1:0] i_bit,
    input  logic             neg,
    output logic             o_valid,
    output logic [LANES-1:0] o_bit,
`ifdef SERIAL_TC_OVF_EN
    output logic [LANES-1:0] ovf,
`endif
    output logic             o_last
);

    localparam int unsigned    CW       = cnt_width(W);
    localparam logic [CW-1:0]  LAST_IDX = CW'(W - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cur_idx;
    tc_mode_e      mode_q, mode_d;
    tc_mode_e      eff_mode;
    logic          valid_q;
    logic          last_q, last_d;
    logic          is_first;
    logic          is_last;

    // A valid i_sof overrides the counter so this bit is bit 0.
    assign cur_idx  = (i_sof && i_valid) ? '0 : cnt_q;
    assign is_first = (cur_idx == '0);
    assign is_last  = (cur_idx == LAST_IDX);
    assign eff_mode = is_first ? tc_mode_e'(neg) : mode_q;

    always_comb begin
        cnt_d  = cnt_q;
        mode_d = mode_q;
        last_d = last_q;
        if (i_valid) begin
            cnt_d  = is_last ? '0 : cur_idx + CW'(1);
            last_d = is_last;
            if (is_first) begin
                mode_d = tc_mode_e'(neg);
            end
        end else if (i_sof) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            cnt_q   <= '0;
            mode_q  <= TC_PASS;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            valid_q <= i_valid;
            last_q  <= last_d;
        end
    end

    assign o_valid = valid_q;
    assign o_last  = last_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        serial_tc_lane u_lane (
            .t_clk   (t_clk),
            .r       (r),
            .i_valid (i_valid),
            .i_first (is_first),
            .i_last  (is_last),
            .i_mode  (eff_mode == TC_NEG),
            .i_bit   (i_bit[g]),
`ifdef SERIAL_TC_OVF_EN
            .o_ovf   (ovf[g]),
`endif
            .o_bit   (o_bit[g])
        );
    end

endmodule

// File: tb/tb_serial_twos_comp.sv
// Scoreboard bench for serial_twos_comp (W=8, LANES=2); expected bits come
// from whole-word arithmetic negation of each issued word.
module tb_serial_twos_comp;

    localparam int W     = 8;
    localparam int LANES = 2;

    logic             t_clk   = 1'b0;
    logic             r       = 1'b0;
    logic             i_valid = 1'b0;
    logic             i_sof   = 1'b0;
    logic             neg     = 1'b0;
    logic [LANES-1:0] i_bit   = '0;
    logic [LANES-1:0] o_bit;
    logic             o_valid;
    logic             o_last;
`ifdef SERIAL_TC_OVF_EN
    logic [LANES-1:0] ovf;
`endif

    serial_twos_comp #(.W(W), .LANES(LANES)) dut (
        .t_clk   (t_clk),
        .r       (r),
        .i_valid (i_valid),
        .i_sof   (i_sof),
        .i_bit   (i_bit),
        .neg     (neg),
        .o_valid (o_valid),
        .o_bit   (o_bit),
`ifdef SERIAL_TC_OVF_EN
        .ovf     (ovf),
`endif
        .o_last  (o_last)
    );

    always #5 t_clk = ~t_clk;

    typedef struct packed {
        logic [1:0] bits;
        logic       last;
        logic [1:0] ovf;
    } exp_t;

    exp_t q[$];
    exp_t last_e = '0;
    int   checks = 0;
    int   errors = 0;
    logic exp_v  = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(posedge t_clk) exp_v <= i_valid && r;

    // Monitor: compares every cycle at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge t_clk);
            if (!r) begin
                last_e = '0;
            end else begin
                check("o_valid", 8'(o_valid), 8'(exp_v));
                if (exp_v) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_empty: got output %0h expected none at %0t", o_bit, $time);
                    end else begin
                        e = q.pop_front();
                        check("o_bit", 8'(o_bit), 8'(e.bits));
                        check("o_last", 8'(o_last), 8'(e.last));
`ifdef SERIAL_TC_OVF_EN
                        check("ovf", 8'(ovf), 8'(e.ovf));
`endif
                        last_e = e;
                    end
                end else begin
                    check("hold_o_bit", 8'(o_bit), 8'(last_e.bits));
                    check("hold_o_last", 8'(o_last), 8'(last_e.last));
`ifdef SERIAL_TC_OVF_EN
                    check("hold_ovf", 8'(ovf), 8'(last_e.ovf));
`endif
                end
            end
        end
    end

    task automatic drive(input logic v, input logic sof, input logic [1:0] b, input logic n);
        @(posedge t_clk);
        #1;
        i_valid = v;
        i_sof   = sof;
        i_bit   = b;
        neg     = n;
    endtask

    task automatic idle(input int k, input logic sof);
        for (int i = 0; i < k; i++) begin
            drive(1'b0, sof && (i == 0), 2'($urandom), 1'($urandom));
        end
    endtask

    // Bits of an abandoned word still match the low bits of the full negation.
    task automatic send_word(input logic [7:0] v0, input logic [7:0] v1, input logic n,
                             input logic sof, input int gap_at, input int stop_at);
        logic [7:0] e0, e1;
        exp_t       e;
        e0 = n ? 8'(8'd0 - v0) : v0;
        e1 = n ? 8'(8'd0 - v1) : v1;
        for (int j = 0; j < 8; j++) begin
            if (j == stop_at) return;
            if (j == gap_at) idle(3, 1'b0);
            e.bits = {e1[j], e0[j]};
            e.last = (j == 7);
            e.ovf  = {n && (j == 7) && (v1 == 8'h80), n && (j == 7) && (v0 == 8'h80)};
            drive(1'b1, sof && (j == 0), {v1[j], v0[j]}, (j == 0) ? n : 1'($urandom));
            q.push_back(e);
        end
    endtask

    initial begin
        #1;
        check("rst_o_valid", 8'(o_valid), 8'h0);
        check("rst_o_bit", 8'(o_bit), 8'h0);
        check("rst_o_last", 8'(o_last), 8'h0);
`ifdef SERIAL_TC_OVF_EN
        check("rst_ovf", 8'(ovf), 8'h0);
`endif
        repeat (2) @(posedge t_clk);
        #1;
        r = 1'b1;

        send_word(8'h06, 8'h00, 1'b1, 1'b1, -1, -1);
        send_word(8'h33, 8'h5A, 1'b0, 1'b1, -1, -1);
        send_word(8'h80, 8'h00, 1'b1, 1'b0, -1, -1);
        send_word(8'h01, 8'h80, 1'b1, 1'b0, -1, -1);
        send_word(8'h80, 8'h80, 1'b0, 1'b0, -1, -1);
        send_word(8'h6C, 8'h93, 1'b1, 1'b1, 3, -1);
        idle(2, 1'b0);
        send_word(8'hA5, 8'h3C, 1'b1, 1'b1, -1, 4);
        send_word(8'h28, 8'hF0, 1'b1, 1'b1, -1, -1);
        send_word(8'h57, 8'h11, 1'b0, 1'b1, -1, 3);
        idle(1, 1'b1);
        send_word(8'h40, 8'h0B, 1'b1, 1'b0, -1, -1);

        // Reset during bit 5 of a word.
        send_word(8'hC4, 8'h2E, 1'b1, 1'b1, -1, 5);
        drive(1'b1, 1'b0, 2'b11, 1'b1);
        @(negedge t_clk);
        #1;
        r = 1'b0;
        #1;
        check("midrst_o_valid", 8'(o_valid), 8'h0);
        check("midrst_o_bit", 8'(o_bit), 8'h0);
        check("midrst_o_last", 8'(o_last), 8'h0);
`ifdef SERIAL_TC_OVF_EN
        check("midrst_ovf", 8'(ovf), 8'h0);
`endif
        i_valid = 1'b0;
        repeat (2) @(posedge t_clk);
        #1;
        r = 1'b1;
        send_word(8'h02, 8'h01, 1'b1, 1'b0, -1, -1);

        send_word(8'h01, 8'h02, 1'b1, 1'b1, -1, -1);
        send_word(8'h02, 8'h01, 1'b1, 1'b0, -1, -1);

        for (int k = 0; k < 40; k++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 5) == 0) a = 8'h80;
            if ($urandom_range(0, 5) == 0) b = 8'h00;
            send_word(a, b, 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : -1, -1);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), 1'b0);
        end

        idle(4, 1'b0);
        check("queue_drained", 8'(q.size()), 8'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
